// File: rtl/arb_pkg.sv
// Shared definitions for the 4-way round-robin arbiter: state encoding, sizes
// and a one-hot helper.
package arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

    localparam int NREQ  = 4;
    localparam int SEL_W = 2;

    function automatic logic [NREQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational rotating-priority picker: first set req bit scanning from ptr
// upward, wrapping 3 -> 0.
module rr_pick4
    import arb_pkg::*;
(
    input  logic [NREQ-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] win,
    output logic             any
);

    logic             found;
    logic [SEL_W-1:0] idx;

    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = '0;
        any   = |req;
        // SEL_W-bit addition wraps naturally, giving the modulo-4 scan order.
        for (int k = 0; k < NREQ; k++) begin
            idx = ptr + SEL_W'(k);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter4.sv
// Round-robin arbiter driving the registered select of a shared 4:1 mux.
// Optional forced release after MAX_HOLD cycles when ARB_TIMEOUT_EN is defined.
module rr_arbiter4
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       in0,
    input  logic       in1,
    input  logic       in2,
    input  logic       in3,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       busy,
    output logic       out,
    output logic       tmo
);

    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("rr_arbiter4: MAX_HOLD must be in 2..255");
    end

    // Protocol: req[i] is a level request; the owner keeps it high for as long
    // as it wants the mux. gnt/sel/busy change only on clock edges, and a drop
    // of req[sel] releases the grant at the next edge with no preemption.

    arb_state_t       state_q, state_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             busy_q, busy_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic             rel;

    logic [SEL_W-1:0] win;
    logic             any;

    rr_pick4 u_pick (
        .req (req),
        .ptr (ptr_q),
        .win (win),
        .any (any)
    );

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
    logic [7:0] cnt_q, cnt_d;
    logic       tmo_q, tmo_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            busy_q  <= 1'b0;
            ptr_q   <= '0;
`ifdef ARB_TIMEOUT_EN
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            ptr_q   <= ptr_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        busy_d  = busy_q;
        ptr_d   = ptr_q;
        rel     = 1'b0;
`ifdef ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        tmo_d   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (any) begin
                    state_d = ST_GRANT;
                    gnt_d   = onehot(win);
                    sel_d   = win;
                    busy_d  = 1'b1;
`ifdef ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            ST_GRANT: begin
                rel = !req[sel_q];
`ifdef ARB_TIMEOUT_EN
                // A voluntary release on the same edge wins, so tmo stays low.
                if (!rel && cnt_q == HOLD_LAST) begin
                    rel   = 1'b1;
                    tmo_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
                if (rel) begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    ptr_d   = sel_q + SEL_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    logic mux_bit;

    always_comb begin
        mux_bit = 1'b0;
        case (sel_q)
            2'd0: mux_bit = in0;
            2'd1: mux_bit = in1;
            2'd2: mux_bit = in2;
            2'd3: mux_bit = in3;
            default: mux_bit = 1'b0;
        endcase
    end

    assign gnt  = gnt_q;
    assign sel  = sel_q;
    assign busy = busy_q;
    assign out  = busy_q & mux_bit;

`ifdef ARB_TIMEOUT_EN
    assign tmo = tmo_q;
`else
    assign tmo = 1'b0;
`endif

endmodule
